rot8x8_blit: RTL and testbench

Sequencer that moves one 8x8-bit tile from memory through the `rot8x8` transpose peripheral and writes the rotated tile back to memory without CPU involvement. It sits between the CPU bus, which uses the same 8-register `AD/DI/DO/rw/cs` slave style, the shared memory master port and the rotator's slave port. Source and destination rows are strided, so tiles can be taken from and placed into framebuffers. The CPU programs addresses and strides, writes START, then polls BUSY/DONE or takes IRQ.

---
 rtl/rot8x8_blit.sv | 214 +++++++++++++++++++++
 tb/tb_rot8x8_blit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot8x8_blit.sv
// rot8x8_blit: DMA-style sequencer that streams one 8x8 tile from memory into the
// rot8x8 peripheral, reads the rotated rows back and stores them with a strided layout.
module rot8x8_blit (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  AD,
   input  logic [7:0]  DI,
   output logic [7:0]  DO,
   input  logic        rw,
   input  logic        cs,
   output logic        irq,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic        rot_cs,
   output logic        rot_rw,
   output logic [2:0]  rot_ad,
   output logic [7:0]  rot_di,
   input  logic [7:0]  rot_do
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_MEM,
      S_LD_ROT,
      S_RD_ROT,
      S_RD_CAP,
      S_ST_MEM,
      S_FIN
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [15:0] r_src;
   logic [15:0] r_dst;
   logic [7:0]  r_sstride;
   logic [7:0]  r_dstride;
   logic        r_irqen;
   logic        r_done;
   logic [15:0] r_sptr;
   logic [15:0] r_dptr;
   logic [2:0]  r_i;
   logic [7:0]  r_data;
   logic [7:0]  r_do;

   logic        w_busy;
   logic        w_cpu_wr;
   logic        w_cpu_rd;
   logic        w_start;
   logic        w_done_clr;
   logic [7:0]  w_rd_data;

   assign w_busy     = (r_state != S_IDLE);
   assign w_cpu_wr   = cs & ~rw;
   assign w_cpu_rd   = cs & rw;
   assign w_start    = w_cpu_wr && (AD == 3'd6) && DI[0] && !w_busy;
   assign w_done_clr = w_cpu_wr && (AD == 3'd7);

   assign DO  = r_do;
   assign irq = r_done & r_irqen;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Bus strobes are decoded purely from state, so address/data cannot move while a request waits.
   always_comb begin
      w_state_next = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = 16'h0000;
      mem_wdata    = 8'h00;
      rot_cs       = 1'b0;
      rot_rw       = 1'b0;
      rot_ad       = 3'd0;
      rot_di       = 8'h00;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_next = S_LD_MEM;
            end
         end
         S_LD_MEM: begin
            mem_req  = 1'b1;
            mem_addr = r_sptr;
            if (mem_ack) begin
               w_state_next = S_LD_ROT;
            end
         end
         S_LD_ROT: begin
            rot_cs       = 1'b1;
            rot_ad       = r_i;
            rot_di       = r_data;
            w_state_next = (r_i == 3'd7) ? S_RD_ROT : S_LD_MEM;
         end
         S_RD_ROT: begin
            rot_cs       = 1'b1;
            rot_rw       = 1'b1;
            rot_ad       = r_i;
            w_state_next = S_RD_CAP;
         end
         S_RD_CAP: begin
            w_state_next = S_ST_MEM;
         end
         S_ST_MEM: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_dptr;
            mem_wdata = r_data;
            if (mem_ack) begin
               w_state_next = (r_i == 3'd7) ? S_FIN : S_RD_ROT;
            end
         end
         S_FIN: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_rd_data = 8'h00;
      case (AD)
         3'd0:    w_rd_data = r_src[7:0];
         3'd1:    w_rd_data = r_src[15:8];
         3'd2:    w_rd_data = r_dst[7:0];
         3'd3:    w_rd_data = r_dst[15:8];
         3'd4:    w_rd_data = r_sstride;
         3'd5:    w_rd_data = r_dstride;
         3'd6:    w_rd_data = {w_busy, 5'b00000, r_irqen, r_done};
         default: w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_src     <= 16'h0000;
         r_dst     <= 16'h0000;
         r_sstride <= 8'h00;
         r_dstride <= 8'h00;
         r_irqen   <= 1'b0;
         r_done    <= 1'b0;
         r_sptr    <= 16'h0000;
         r_dptr    <= 16'h0000;
         r_i       <= 3'd0;
         r_data    <= 8'h00;
         r_do      <= 8'h00;
      end else begin
         // Configuration is frozen while a transfer runs; only IRQEN stays live.
         if (w_cpu_wr) begin
            case (AD)
               3'd0: if (!w_busy) r_src[7:0]  <= DI;
               3'd1: if (!w_busy) r_src[15:8] <= DI;
               3'd2: if (!w_busy) r_dst[7:0]  <= DI;
               3'd3: if (!w_busy) r_dst[15:8] <= DI;
               3'd4: if (!w_busy) r_sstride   <= DI;
               3'd5: if (!w_busy) r_dstride   <= DI;
               3'd6: r_irqen <= DI[1];
               default: ;
            endcase
         end

         if (r_state == S_FIN) begin
            r_done <= 1'b1;
         end else if (w_start || w_done_clr) begin
            r_done <= 1'b0;
         end

         if (w_cpu_rd) begin
            r_do <= w_rd_data;
         end

         if (w_start) begin
            r_sptr <= r_src;
            r_dptr <= r_dst;
            r_i    <= 3'd0;
         end

         // Row counter wraps 7 -> 0 naturally, which reseeds it for the readback phase.
         case (r_state)
            S_LD_MEM: begin
               if (mem_ack) begin
                  r_data <= mem_rdata;
                  r_sptr <= r_sptr + {8'h00, r_sstride};
               end
            end
            S_LD_ROT: begin
               r_i <= r_i + 3'd1;
            end
            S_RD_CAP: begin
               r_data <= rot_do;
            end
            S_ST_MEM: begin
               if (mem_ack) begin
                  r_dptr <= r_dptr + {8'h00, r_dstride};
                  r_i    <= r_i + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rot8x8_blit.sv
// Directed bench for rot8x8_blit with a behavioural memory (programmable wait states)
// and a behavioural rot8x8 rotator.
module tb_rot8x8_blit;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  AD;
   logic [7:0]  DI;
   logic [7:0]  DO;
   logic        rw;
   logic        cs;
   logic        irq;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic        rot_cs;
   logic        rot_rw;
   logic [2:0]  rot_ad;
   logic [7:0]  rot_di;
   logic [7:0]  rot_do;

   rot8x8_blit dut (
      .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .irq(irq),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .rot_cs(rot_cs), .rot_rw(rot_rw), .rot_ad(rot_ad), .rot_di(rot_di), .rot_do(rot_do)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory model ----------------
   logic [7:0]  mem [0:65535];
   int          waits = 0;
   int          wcnt = 0;
   logic        tb_wr = 1'b0;
   logic [15:0] tb_waddr = 16'h0;
   logic [7:0]  tb_wdata = 8'h0;
   logic        log_clr = 1'b0;
   logic [15:0] rd_log [0:31];
   logic [15:0] wr_log [0:31];
   int          n_rd = 0;
   int          n_wr = 0;
   int          n_req = 0;
   logic        stab_err = 1'b0;
   logic        p_pend = 1'b0;
   logic [15:0] p_addr;
   logic        p_we;
   logic [7:0]  p_wdata;

   assign mem_ack   = mem_req && (wcnt == waits);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (tb_wr) mem[tb_waddr] <= tb_wdata;
      wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
      if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
      if (log_clr) begin
         n_rd <= 0; n_wr <= 0; n_req <= 0; stab_err <= 1'b0;
      end else begin
         if (mem_req) n_req <= n_req + 1;
         if (mem_req && mem_ack) begin
            if (mem_we) begin
               if (n_wr < 32) wr_log[n_wr] <= mem_addr;
               n_wr <= n_wr + 1;
            end else begin
               if (n_rd < 32) rd_log[n_rd] <= mem_addr;
               n_rd <= n_rd + 1;
            end
         end
         // A pending request must persist unchanged until acknowledged.
         if (p_pend && rst && (!mem_req || mem_addr !== p_addr || mem_we !== p_we ||
                               (p_we && mem_wdata !== p_wdata)))
            stab_err <= 1'b1;
      end
      p_pend  <= mem_req && !mem_ack && rst;
      p_addr  <= mem_addr;
      p_we    <= mem_we;
      p_wdata <= mem_wdata;
   end

   // ---------------- rotator model: out[r] bit j = row j bit (7-r) ----------------
   logic [7:0] rot_mem [0:7];

   function automatic logic [7:0] rot_row(input logic [2:0] r);
      logic [7:0] v;
      for (int j = 0; j < 8; j++) v[j] = rot_mem[j][3'd7 - r];
      return v;
   endfunction

   always @(posedge clk) begin
      if (rot_cs && !rot_rw) rot_mem[rot_ad] <= rot_di;
      if (rot_cs && rot_rw) rot_do <= rot_row(rot_ad);
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; rw = 1'b0; AD = a; DI = d;
      @(negedge clk);
      cs = 1'b0; rw = 1'b1;
   endtask

   task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; rw = 1'b1; AD = a;
      @(negedge clk);
      cs = 1'b0;
      d = DO;
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      tb_wr = 1'b1; tb_waddr = a; tb_wdata = d;
      @(negedge clk);
      tb_wr = 1'b0;
   endtask

   task automatic clear_log();
      @(negedge clk);
      log_clr = 1'b1;
      @(negedge clk);
      log_clr = 1'b0;
   endtask

   task automatic program_regs(input logic [15:0] s, input logic [15:0] d,
                               input logic [7:0] ss, input logic [7:0] ds);
      cpu_wr(3'd0, s[7:0]);  cpu_wr(3'd1, s[15:8]);
      cpu_wr(3'd2, d[7:0]);  cpu_wr(3'd3, d[15:8]);
      cpu_wr(3'd4, ss);      cpu_wr(3'd5, ds);
   endtask

   task automatic load_tile(input logic [15:0] s, input logic [15:0] d,
                            input logic [7:0] ss, input logic [7:0] ds);
      for (int k = 0; k < 8; k++) begin
         poke(s + 16'(k) * {8'h00, ss}, 8'h01 << k);
         poke(d + 16'(k) * {8'h00, ds}, 8'h00);
      end
   endtask

   task automatic wait_irq(output int lat, input int t0);
      lat = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (irq) begin
            lat = cyc - t0;
            break;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " DO"}, 32'(DO), 32'h00);
      check({tag, " irq"}, 32'(irq), 32'h0);
      check({tag, " mem_req"}, 32'(mem_req), 32'h0);
      check({tag, " mem_we"}, 32'(mem_we), 32'h0);
      check({tag, " mem_addr"}, 32'(mem_addr), 32'h0000);
      check({tag, " mem_wdata"}, 32'(mem_wdata), 32'h00);
      check({tag, " rot_cs"}, 32'(rot_cs), 32'h0);
      check({tag, " rot_rw"}, 32'(rot_rw), 32'h0);
      check({tag, " rot_ad"}, 32'(rot_ad), 32'h0);
      check({tag, " rot_di"}, 32'(rot_di), 32'h00);
   endtask

   typedef struct {
      logic       wr;
      logic [2:0] ad;
      logic [7:0] di;
      logic [7:0] exp;
   } reg_vec_t;

   typedef struct {
      logic [15:0] src;
      logic [15:0] dst;
      logic [7:0]  ss;
      logic [7:0]  ds;
      int          waits;
      int          lat;
   } xfer_t;

   reg_vec_t rv [0:16];
   xfer_t    xv [0:3];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0]  d;
      logic [15:0] a;
      int          lat;
      int          t0;
      int          found;

      rv[0]  = '{1'b1, 3'd0, 8'h34, 8'h00};
      rv[1]  = '{1'b1, 3'd1, 8'h12, 8'h00};
      rv[2]  = '{1'b1, 3'd2, 8'h78, 8'h00};
      rv[3]  = '{1'b1, 3'd3, 8'h56, 8'h00};
      rv[4]  = '{1'b1, 3'd4, 8'h9A, 8'h00};
      rv[5]  = '{1'b1, 3'd5, 8'hBC, 8'h00};
      rv[6]  = '{1'b0, 3'd0, 8'h00, 8'h34};
      rv[7]  = '{1'b0, 3'd1, 8'h00, 8'h12};
      rv[8]  = '{1'b0, 3'd2, 8'h00, 8'h78};
      rv[9]  = '{1'b0, 3'd3, 8'h00, 8'h56};
      rv[10] = '{1'b0, 3'd4, 8'h00, 8'h9A};
      rv[11] = '{1'b0, 3'd5, 8'h00, 8'hBC};
      rv[12] = '{1'b0, 3'd7, 8'h00, 8'h00};
      rv[13] = '{1'b1, 3'd6, 8'h02, 8'h00};
      rv[14] = '{1'b0, 3'd6, 8'h00, 8'h02};
      rv[15] = '{1'b1, 3'd6, 8'h00, 8'h00};
      rv[16] = '{1'b0, 3'd6, 8'h00, 8'h00};

      xv[0] = '{16'h1000, 16'h2000, 8'h01, 8'h01, 0, 41};
      xv[1] = '{16'h3000, 16'h4000, 8'h28, 8'h50, 0, 41};
      xv[2] = '{16'hFFF0, 16'h5000, 8'h10, 8'h01, 0, 41};
      xv[3] = '{16'h8000, 16'h9000, 8'h02, 8'h03, 3, 89};

      rst = 1'b0; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b1;

      // Register file vectors
      for (int v = 0; v < 17; v++) begin
         if (rv[v].wr) begin
            cpu_wr(rv[v].ad, rv[v].di);
         end else begin
            cpu_rd(rv[v].ad, d);
            check($sformatf("reg%0d rd v%0d", rv[v].ad, v), 32'(d), 32'(rv[v].exp));
         end
      end

      // Transfer vectors: source row k = 1<<k, so rotated row k = 0x80>>k
      for (int x = 0; x < 4; x++) begin
         waits = xv[x].waits;
         load_tile(xv[x].src, xv[x].dst, xv[x].ss, xv[x].ds);
         program_regs(xv[x].src, xv[x].dst, xv[x].ss, xv[x].ds);
         clear_log();
         cpu_wr(3'd6, 8'h03);
         t0 = cyc;
         wait_irq(lat, t0);
         check($sformatf("x%0d latency", x), 32'(lat), 32'(xv[x].lat));
         cpu_rd(3'd6, d);
         check($sformatf("x%0d stat", x), 32'(d), 32'h03);
         check($sformatf("x%0d reads", x), 32'(n_rd), 32'd8);
         check($sformatf("x%0d writes", x), 32'(n_wr), 32'd8);
         check($sformatf("x%0d stable", x), 32'(stab_err), 32'h0);
         for (int k = 0; k < 8; k++) begin
            a = xv[x].src + 16'(k) * {8'h00, xv[x].ss};
            check($sformatf("x%0d rd_addr%0d", x, k), 32'(rd_log[k]), 32'(a));
            a = xv[x].dst + 16'(k) * {8'h00, xv[x].ds};
            check($sformatf("x%0d wr_addr%0d", x, k), 32'(wr_log[k]), 32'(a));
            check($sformatf("x%0d data%0d", x, k), 32'(mem[a]), 32'(8'h80 >> k));
         end
         cpu_wr(3'd7, 8'h00);
         check($sformatf("x%0d irq_clr", x), 32'(irq), 32'h0);
      end

      // Busy protection: SRC and START writes during a transfer are ignored
      waits = 1;
      load_tile(16'h6000, 16'h7000, 8'h01, 8'h01);
      program_regs(16'h6000, 16'h7000, 8'h01, 8'h01);
      clear_log();
      cpu_wr(3'd6, 8'h03);
      t0 = cyc;
      cpu_rd(3'd6, d);
      check("busy stat", 32'(d), 32'h82);
      cpu_wr(3'd0, 8'hAA);
      cpu_wr(3'd1, 8'hAA);
      cpu_wr(3'd6, 8'h03);
      wait_irq(lat, t0);
      check("busy done", 32'(lat), 32'd57);
      check("busy accesses", 32'(n_rd + n_wr), 32'd16);
      check("busy rd0", 32'(rd_log[0]), 32'h6000);
      check("busy rd7", 32'(rd_log[7]), 32'h6007);
      check("busy wr7", 32'(wr_log[7]), 32'h7007);
      check("busy data0", 32'(mem[16'h7000]), 32'h80);
      cpu_rd(3'd0, d);
      check("busy src_lo", 32'(d), 32'h00);
      cpu_rd(3'd1, d);
      check("busy src_hi", 32'(d), 32'h60);
      clear_log();
      repeat (20) @(negedge clk);
      check("busy no restart", 32'(n_req), 32'd0);
      check("busy irq held", 32'(irq), 32'h1);

      // START while DONE=1 clears DONE; then reset in the middle of a store
      waits = 3;
      program_regs(16'hA000, 16'hB055, 8'h01, 8'h01);
      cpu_wr(3'd6, 8'h03);
      cpu_rd(3'd6, d);
      check("restart stat", 32'(d), 32'h82);
      cpu_rd(3'd2, d);
      check("restart dst_lo", 32'(d), 32'h55);
      found = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (mem_req && mem_we) begin
            found = 1;
            break;
         end
      end
      check("reach st_mem", 32'(found), 32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("midrst");
      rst = 1'b1;
      cpu_rd(3'd6, d);
      check("midrst stat", 32'(d), 32'h00);
      cpu_rd(3'd0, d);
      check("midrst src_lo", 32'(d), 32'h00);
      clear_log();
      repeat (50) @(negedge clk);
      check("midrst no req", 32'(n_req), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
